// File: rtl/icache_refill_bridge_if.sv
// icache_refill_bridge_if: bundle of cache-side and memory-side signals of the refill bridge
//   master : bridge view; drives DataIn/ready/word_idx/refill_done/busy, mem_req/mem_addr, protocol_err
//            and receives IM_enable/IM_address from the cache and mem_gnt/mem_rvalid/mem_rdata from memory
//   slave  : cache controller + memory view, the mirror of master
interface icache_refill_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              IM_enable;
  logic [ADDR_W-1:0] IM_address;
  logic [DATA_W-1:0] DataIn;
  logic              ready;
  logic [1:0]        word_idx;
  logic              refill_done;
  logic              busy;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              protocol_err;
  modport master (
    input  IM_enable, IM_address, mem_gnt, mem_rvalid, mem_rdata,
    output DataIn, ready, word_idx, refill_done, busy, mem_req, mem_addr, protocol_err
  );
  modport slave (
    output IM_enable, IM_address, mem_gnt, mem_rvalid, mem_rdata,
    input  DataIn, ready, word_idx, refill_done, busy, mem_req, mem_addr, protocol_err
  );
endinterface

// File: rtl/icache_refill_bridge.sv
// icache_refill_bridge: fetches a 4-word instruction line, one read outstanding at a time, words 0..3 in order
//   clk : rising-edge clock
//   rst : synchronous active-low reset
//   bus : icache_refill_bridge_if.master (cache request/response + memory request/response)
module icache_refill_bridge #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4
) (
  input logic                    clk,
  input logic                    rst,
  icache_refill_bridge_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t            r_state;
  logic [1:0]        r_cnt;
  logic [ADDR_W-5:0] r_base;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_idx;
  logic              r_ready;
  logic              r_done;
  logic              r_busy;
  logic              r_req;
  logic [ADDR_W-1:0] r_addr;
  logic              r_err;
  logic [1:0]        w_cnt_nxt;
  logic              w_last;
  logic              w_unused;
  assign w_cnt_nxt = r_cnt + 2'd1;
  assign w_last    = r_cnt == 2'(LINE_WORDS - 1);
  // byte offset within the line is irrelevant: the line is always fetched from its base
  assign w_unused  = ^bus.IM_address[3:0];
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_base  <= '0;
      r_data  <= '0;
      r_idx   <= '0;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      // a response is only legal while a read is outstanding; anything else is dropped and flagged
      if (bus.mem_rvalid && r_state != WAIT) r_err <= 1'b1;
      case (r_state)
        IDLE: if (bus.IM_enable) begin
          r_base  <= bus.IM_address[ADDR_W-1:4];
          r_cnt   <= '0;
          r_addr  <= {bus.IM_address[ADDR_W-1:4], 4'b0000};
          r_req   <= 1'b1;
          r_busy  <= 1'b1;
          r_state <= REQ;
        end
        REQ: if (bus.mem_gnt) begin
          r_req   <= 1'b0;
          r_state <= WAIT;
        end
        WAIT: if (bus.mem_rvalid) begin
          r_data  <= bus.mem_rdata;
          r_idx   <= r_cnt;
          r_ready <= 1'b1;
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= DONE;
          end else begin
            r_cnt   <= w_cnt_nxt;
            r_addr  <= {r_base, w_cnt_nxt, 2'b00};
            r_req   <= 1'b1;
            r_state <= REQ;
          end
        end
        DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.DataIn       = r_data;
  assign bus.ready        = r_ready;
  assign bus.word_idx     = r_idx;
  assign bus.refill_done  = r_done;
  assign bus.busy         = r_busy;
  assign bus.mem_req      = r_req;
  assign bus.mem_addr     = r_addr;
  assign bus.protocol_err = r_err;
endmodule

// File: tb/tb_icache_refill_bridge.sv
// tb_icache_refill_bridge: scoreboard bench with a cycle-stepped memory model for icache_refill_bridge
module tb_icache_refill_bridge;
  typedef struct {logic [31:0] data; logic [1:0] idx; int cyc;} exp_t;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  icache_refill_bridge_if #(.ADDR_W(32), .DATA_W(32)) b();
  icache_refill_bridge #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(b)
  );
  exp_t        sb[$];
  logic [31:0] exp_addr[$];
  int          delays[$];
  int          stalls[$];
  int          tests = 0, fails = 0;
  int          cyc = 0, n_done = 0, n_ready = 0, n_grant = 0;
  int          last_done = 0, last_ready = 0, gap = -1, en_stop_at = -1;
  bit          pend = 0, in_req = 0, in_line = 0, drop_mid = 0, spur_rv = 0;
  bit          busy_bad = 0, hold_bad = 0;
  int          pend_wait = 0, stall = 0;
  logic [31:0] pend_addr, pend_exp, held_addr;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  // one cycle: observe DUT outputs, then drive memory inputs for the next rising edge
  task automatic step();
    exp_t e;
    tick();
    if (b.ready) begin
      n_ready++;
      last_ready = cyc;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_ready: got ready=1 idx=%0d want no strobe (cycle %0d)", b.word_idx, cyc);
      end else begin
        e = sb.pop_front();
        if (b.DataIn !== e.data || b.word_idx !== e.idx || cyc != e.cyc) begin
          fails++;
          $display("FAIL ready_beat: got data=%h idx=%0d cyc=%0d want data=%h idx=%0d cyc=%0d",
                   b.DataIn, b.word_idx, cyc, e.data, e.idx, e.cyc);
        end
      end
    end
    if (b.refill_done) begin
      n_done++;
      last_done = cyc;
      in_line = 0;
      if (n_done == en_stop_at) b.IM_enable = 1'b0;
      tests++;
      if (b.mem_req !== 1'b0 || b.busy !== 1'b0) begin
        fails++;
        $display("FAIL done_overlap: got mem_req=%b busy=%b want 0 0", b.mem_req, b.busy);
      end
    end else if (in_line && b.busy !== 1'b1) busy_bad = 1;
    if (b.mem_req && !in_line) begin
      in_line = 1;
      if (n_done > 0) gap = cyc - last_done;
    end
    if (drop_mid && b.ready && b.word_idx == 2'd0) begin
      b.IM_enable  = 1'b0;
      b.IM_address = 32'hFFFF_FFF0;
    end
    b.mem_gnt    = 1'b0;
    b.mem_rvalid = 1'b0;
    b.mem_rdata  = 32'hDEAD_BEEF;
    if (pend) begin
      pend_wait--;
      if (pend_wait <= 0) begin
        b.mem_rvalid = 1'b1;
        b.mem_rdata  = mdata(pend_addr);
        e.data = mdata(pend_exp);
        e.idx  = pend_exp[3:2];
        e.cyc  = cyc + 1;
        sb.push_back(e);
        pend = 0;
      end
    end else if (b.mem_req) begin
      if (!in_req) begin
        in_req    = 1;
        stall     = stalls.size() ? stalls.pop_front() : 0;
        held_addr = b.mem_addr;
      end
      if (stall > 0) begin
        stall--;
        if (b.mem_addr !== held_addr) hold_bad = 1;
      end else begin
        b.mem_gnt = 1'b1;
        in_req    = 0;
        n_grant++;
        pend_exp  = b.mem_addr;
        tests++;
        if (exp_addr.size() == 0) begin
          fails++;
          $display("FAIL unexpected_req: got mem_addr=%h want no request", b.mem_addr);
        end else begin
          pend_exp = exp_addr.pop_front();
          if (b.mem_addr !== pend_exp) begin
            fails++;
            $display("FAIL mem_addr: got %h want %h", b.mem_addr, pend_exp);
          end
        end
        if (spur_rv) begin
          b.mem_rvalid = 1'b1;
          b.mem_rdata  = 32'hBAD0_0000;
          spur_rv = 0;
        end
        pend      = 1;
        pend_addr = b.mem_addr;
        pend_wait = delays.size() ? delays.pop_front() : 1;
      end
    end else if (in_req) begin
      hold_bad = 1;
      in_req   = 0;
    end
  endtask

  task automatic run_until_done(input int target, input string name);
    int n = 0;
    while (n_done < target && n < 300) begin
      step();
      n++;
    end
    tests++;
    if (n_done < target) begin
      fails++;
      $display("FAIL %s_timeout: got %0d lines done want %0d", name, n_done, target);
    end
    tests++;
    if (sb.size() != 0 || exp_addr.size() != 0) begin
      fails++;
      $display("FAIL %s_leftover: got %0d beats %0d addrs pending want 0 0", name, sb.size(), exp_addr.size());
    end
  endtask

  task automatic clear_model();
    pend = 0; in_req = 0; in_line = 0; drop_mid = 0; spur_rv = 0;
    busy_bad = 0; hold_bad = 0;
    sb.delete(); exp_addr.delete(); delays.delete(); stalls.delete();
    b.mem_gnt = 1'b0; b.mem_rvalid = 1'b0; b.IM_enable = 1'b0;
  endtask

  task automatic do_reset();
    clear_model();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    b.IM_enable = 1'b1; b.IM_address = 32'h1234; b.mem_gnt = 1'b1; b.mem_rvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if ({b.DataIn, b.ready, b.word_idx, b.refill_done, b.busy, b.mem_req, b.mem_addr, b.protocol_err} !== 71'd0) begin
        fails++;
        $display("FAIL reset_outputs: got data=%h rdy=%b idx=%0d done=%b busy=%b req=%b addr=%h err=%b want all 0",
                 b.DataIn, b.ready, b.word_idx, b.refill_done, b.busy, b.mem_req, b.mem_addr, b.protocol_err);
      end
    end
    b.IM_enable = 1'b0; b.mem_gnt = 1'b0; b.mem_rvalid = 1'b0;
    rst = 1'b1;
    tick();
    tests++;
    if (b.busy !== 1'b0 || b.mem_req !== 1'b0 || b.protocol_err !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: got busy=%b req=%b err=%b want 0 0 0", b.busy, b.mem_req, b.protocol_err);
    end
  endtask

  task automatic test_basic();
    int r0 = n_ready;
    exp_addr = {32'h1230, 32'h1234, 32'h1238, 32'h123C};
    busy_bad = 0;
    b.IM_address = 32'h0000_1234;
    b.IM_enable  = 1'b1;
    step();
    b.IM_enable  = 1'b0;
    run_until_done(n_done + 1, "basic");
    tests++;
    if (n_ready - r0 != 4 || last_done - last_ready != 1) begin
      fails++;
      $display("FAIL basic_strobes: got %0d readys done_after=%0d want 4 readys done_after=1", n_ready - r0, last_done - last_ready);
    end
    tests++;
    if (busy_bad || b.protocol_err !== 1'b0) begin
      fails++;
      $display("FAIL basic_status: got busy_drop=%0d err=%b want 0 0", busy_bad, b.protocol_err);
    end
  endtask

  task automatic test_backpressure();
    int r0 = n_ready;
    exp_addr = {32'h1230, 32'h1234, 32'h1238, 32'h123C};
    stalls   = {0, 0, 3, 0};
    hold_bad = 0;
    b.IM_address = 32'h0000_1234;
    b.IM_enable  = 1'b1;
    step();
    b.IM_enable  = 1'b0;
    run_until_done(n_done + 1, "backpressure");
    tests++;
    if (hold_bad || n_ready - r0 != 4) begin
      fails++;
      $display("FAIL backpressure_hold: got unstable=%0d readys=%0d want 0 4", hold_bad, n_ready - r0);
    end
  endtask

  task automatic test_latency();
    exp_addr = {32'h0000_ABC0, 32'h0000_ABC4, 32'h0000_ABC8, 32'h0000_ABCC};
    delays   = {1, 5, 2, 7};
    busy_bad = 0;
    b.IM_address = 32'h0000_ABC8;
    b.IM_enable  = 1'b1;
    step();
    b.IM_enable  = 1'b0;
    run_until_done(n_done + 1, "latency");
    tests++;
    if (busy_bad) begin
      fails++;
      $display("FAIL latency_busy: got busy low mid-line want busy high throughout");
    end
  endtask

  task automatic test_mid_drop();
    exp_addr = {32'h1230, 32'h1234, 32'h1238, 32'h123C};
    drop_mid = 1;
    b.IM_address = 32'h0000_1234;
    b.IM_enable  = 1'b1;
    run_until_done(n_done + 1, "mid_drop");
    drop_mid = 0;
    for (int i = 0; i < 4; i++) step();
    tests++;
    if (b.busy !== 1'b0 || b.mem_req !== 1'b0) begin
      fails++;
      $display("FAIL mid_drop_idle: got busy=%b req=%b want 0 0", b.busy, b.mem_req);
    end
  endtask

  task automatic test_reset_mid();
    int g0 = n_grant, r0, d0, n = 0;
    exp_addr = {32'h0000_5670, 32'h0000_5674};
    delays   = {1, 6};
    b.IM_address = 32'h0000_5678;
    b.IM_enable  = 1'b1;
    step();
    b.IM_enable  = 1'b0;
    while (n_grant < g0 + 2 && n < 50) begin
      step();
      n++;
    end
    step();
    tests++;
    if (n_grant != g0 + 2 || b.busy !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_setup: got grants=%0d busy=%b want %0d 1", n_grant - g0, b.busy, 2);
    end
    r0 = n_ready;
    d0 = n_done;
    rst = 1'b0;
    b.mem_gnt = 1'b0; b.mem_rvalid = 1'b0;
    tick();
    tests++;
    if ({b.DataIn, b.ready, b.word_idx, b.refill_done, b.busy, b.mem_req, b.mem_addr, b.protocol_err} !== 71'd0) begin
      fails++;
      $display("FAIL reset_mid_outputs: got data=%h rdy=%b idx=%0d done=%b busy=%b req=%b addr=%h err=%b want all 0",
               b.DataIn, b.ready, b.word_idx, b.refill_done, b.busy, b.mem_req, b.mem_addr, b.protocol_err);
    end
    rst = 1'b1;
    b.mem_rvalid = 1'b1;
    b.mem_rdata  = 32'hBAD0_0001;
    tick();
    b.mem_rvalid = 1'b0;
    tests++;
    if (b.protocol_err !== 1'b1) begin
      fails++;
      $display("FAIL late_rvalid_err: got %b want 1", b.protocol_err);
    end
    tick();
    tick();
    tests++;
    if (b.ready !== 1'b0 || b.refill_done !== 1'b0 || b.protocol_err !== 1'b1 || b.DataIn !== 32'd0) begin
      fails++;
      $display("FAIL late_rvalid_discard: got rdy=%b done=%b err=%b data=%h want 0 0 1 0",
               b.ready, b.refill_done, b.protocol_err, b.DataIn);
    end
    tests++;
    if (n_ready != r0 || n_done != d0) begin
      fails++;
      $display("FAIL reset_mid_strobes: got %0d readys %0d dones after abort want 0 0", n_ready - r0, n_done - d0);
    end
    do_reset();
    tick();
    tests++;
    if (b.protocol_err !== 1'b0) begin
      fails++;
      $display("FAIL err_clear_on_reset: got %b want 0", b.protocol_err);
    end
  endtask

  task automatic test_gnt_rvalid();
    int r0 = n_ready;
    exp_addr = {32'h0000_0040, 32'h0000_0044, 32'h0000_0048, 32'h0000_004C};
    spur_rv  = 1;
    b.IM_address = 32'h0000_004C;
    b.IM_enable  = 1'b1;
    step();
    b.IM_enable  = 1'b0;
    run_until_done(n_done + 1, "gnt_rvalid");
    tests++;
    if (b.protocol_err !== 1'b1 || n_ready - r0 != 4) begin
      fails++;
      $display("FAIL gnt_rvalid_err: got err=%b readys=%0d want 1 4", b.protocol_err, n_ready - r0);
    end
    do_reset();
  endtask

  task automatic test_back_to_back();
    exp_addr   = {32'h1000, 32'h1004, 32'h1008, 32'h100C, 32'h2000, 32'h2004, 32'h2008, 32'h200C};
    en_stop_at = n_done + 2;
    gap        = -1;
    b.IM_address = 32'h0000_1000;
    b.IM_enable  = 1'b1;
    step();
    b.IM_address = 32'h0000_2000;
    run_until_done(n_done + 2, "back_to_back");
    en_stop_at = -1;
    b.IM_enable = 1'b0;
    tests++;
    if (gap != 1) begin
      fails++;
      $display("FAIL b2b_restart: got second mem_req %0d cycles after refill_done want 1", gap);
    end
    for (int i = 0; i < 3; i++) step();
    tests++;
    if (b.busy !== 1'b0 || b.mem_req !== 1'b0) begin
      fails++;
      $display("FAIL b2b_idle: got busy=%b req=%b want 0 0", b.busy, b.mem_req);
    end
  endtask

  initial begin
    rst = 1'b0;
    b.IM_enable = 1'b0; b.IM_address = '0;
    b.mem_gnt = 1'b0; b.mem_rvalid = 1'b0; b.mem_rdata = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_latency();
    test_mid_drop();
    test_reset_mid();
    test_gnt_rvalid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end
endmodule
